// File: rtl/eth_traffic_gen.sv
// eth_traffic_gen -- Ethernet frame generator producing a header handshake
// plus a byte-wide AXI-Stream payload.
//
// Every payload starts with a 4-byte big-endian frame sequence number,
// followed by a pattern selected by cfg_mode:
//   0 and 3 : byte i = i[7:0]
//   1       : PRBS-31, only when TRAFFIC_GEN_PRBS_EN is defined; otherwise as 0
//   2       : constant 8'hA5
// A run sends cfg_count frames, or runs until stop when cfg_count is 0.
// Frames are separated by cfg_gap idle cycles.
//
// Optional feature macro: TRAFFIC_GEN_PRBS_EN
//   Adds a PRBS-31 generator (x^31 + x^28 + 1), reseeded to all-ones for every
//   frame, 8 bits per byte with the first bit in the MSB.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   start, stop                    single-cycle run control pulses
//   cfg_mode/len/count/gap         run configuration, latched on accepted start
//   m_eth_hdr_valid/ready          header handshake
//   m_eth_dest_mac/src_mac/type    constant header fields
//   m_eth_payload_axis_*           payload byte stream (tuser always 0)
//   busy                           run in progress
//   frames_sent                    frames completed since the last accepted start
module eth_traffic_gen #(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_00,
  parameter logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [15:0] ETH_TYPE  = 16'h88B5,
  parameter int          MIN_LEN   = 46,
  parameter int          MAX_LEN   = 1500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  cfg_mode,
  input  logic [15:0] cfg_len,
  input  logic [31:0] cfg_count,
  input  logic [15:0] cfg_gap,
  output logic        m_eth_hdr_valid,
  input  logic        m_eth_hdr_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [7:0]  m_eth_payload_axis_tdata,
  output logic        m_eth_payload_axis_tvalid,
  input  logic        m_eth_payload_axis_tready,
  output logic        m_eth_payload_axis_tlast,
  output logic        m_eth_payload_axis_tuser,
  output logic        busy,
  output logic [31:0] frames_sent
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_GAP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  mode_q;
  logic [15:0] len_q;
  logic [31:0] count_q;
  logic [15:0] gap_q;
  logic [15:0] byte_idx;
  logic [15:0] gap_cnt;
  logic        stop_seen;

  logic [15:0] len_clamped;
  logic        beat;
  logic        last_beat;
  logic [31:0] frames_inc;
  logic        run_done;
  logic        start_ok;

  // Header fields never change.
  assign m_eth_dest_mac = DST_MAC;
  assign m_eth_src_mac  = LOCAL_MAC;
  assign m_eth_type     = ETH_TYPE;

  // All handshake outputs are decoded from the registered state, so reset
  // clears them as soon as the state register clears.
  assign m_eth_hdr_valid           = (state == S_HDR);
  assign m_eth_payload_axis_tvalid = (state == S_PAYLOAD);
  assign m_eth_payload_axis_tlast  = (state == S_PAYLOAD) && (byte_idx == len_q - 16'd1);
  assign m_eth_payload_axis_tuser  = 1'b0;
  assign busy                      = (state != S_IDLE);

  assign start_ok   = (state == S_IDLE) && start;
  assign beat       = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready;
  assign last_beat  = beat && m_eth_payload_axis_tlast;
  assign frames_inc = frames_sent + 32'd1;
  // A stop pulse arriving on the final beat itself also ends the run.
  assign run_done   = stop_seen || stop || ((count_q != 32'd0) && (frames_inc == count_q));

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len < 16'(MIN_LEN))      len_clamped = 16'(MIN_LEN);
    else if (cfg_len > 16'(MAX_LEN)) len_clamped = 16'(MAX_LEN);
  end

  // NOTE: every signal driven by an always_comb gets a default at the top so
  // that no path leaves it unassigned; an unassigned path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_HDR;
      S_HDR:     if (m_eth_hdr_ready) state_nxt = S_PAYLOAD;
      S_PAYLOAD: begin
        if (last_beat) begin
          if (run_done)            state_nxt = S_IDLE;
          else if (gap_q == 16'd0) state_nxt = S_HDR;
          else                     state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (stop_seen || stop)      state_nxt = S_IDLE;
        else if (gap_cnt == 16'd1) state_nxt = S_HDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mode_q      <= 2'd0;
      len_q       <= 16'(MIN_LEN);
      count_q     <= 32'd0;
      gap_q       <= 16'd0;
      byte_idx    <= 16'd0;
      gap_cnt     <= 16'd0;
      stop_seen   <= 1'b0;
      frames_sent <= 32'd0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        // Stop in the same cycle as an accepted start is ignored.
        mode_q      <= cfg_mode;
        len_q       <= len_clamped;
        count_q     <= cfg_count;
        gap_q       <= cfg_gap;
        byte_idx    <= 16'd0;
        stop_seen   <= 1'b0;
        frames_sent <= 32'd0;
      end else begin
        if (stop && (state != S_IDLE)) stop_seen <= 1'b1;
        if (beat) byte_idx <= last_beat ? 16'd0 : byte_idx + 16'd1;
        // frames_sent doubles as the sequence number carried in bytes 0..3.
        if (last_beat) frames_sent <= frames_inc;
        if (last_beat)            gap_cnt <= gap_q;
        else if (state == S_GAP)  gap_cnt <= gap_cnt - 16'd1;
      end
    end
  end

`ifdef TRAFFIC_GEN_PRBS_EN
  logic [30:0] lfsr;
  logic [7:0]  prbs_byte;
  logic [30:0] lfsr_nxt;

  // Advance the Fibonacci LFSR eight steps; output bit is the oldest stage.
  function automatic logic [38:0] prbs_step(input logic [30:0] s);
    logic [30:0] st;
    logic [7:0]  b;
    st = s;
    b  = 8'd0;
    for (int i = 0; i < 8; i++) begin
      b[7-i] = st[30];
      st     = {st[29:0], st[30] ^ st[27]};
    end
    return {b, st};
  endfunction

  assign {prbs_byte, lfsr_nxt} = prbs_step(lfsr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                lfsr <= '1;
    else if (state == S_HDR)                   lfsr <= '1;
    else if (beat && (byte_idx >= 16'd4))      lfsr <= lfsr_nxt;
  end
`endif

  always_comb begin
    m_eth_payload_axis_tdata = 8'd0;
    if (state == S_PAYLOAD) begin
      if (byte_idx < 16'd4) begin
        unique case (byte_idx[1:0])
          2'd0: m_eth_payload_axis_tdata = frames_sent[31:24];
          2'd1: m_eth_payload_axis_tdata = frames_sent[23:16];
          2'd2: m_eth_payload_axis_tdata = frames_sent[15:8];
          default: m_eth_payload_axis_tdata = frames_sent[7:0];
        endcase
      end else begin
        unique case (mode_q)
          2'd2:    m_eth_payload_axis_tdata = 8'hA5;
`ifdef TRAFFIC_GEN_PRBS_EN
          2'd1:    m_eth_payload_axis_tdata = prbs_byte;
`endif
          default: m_eth_payload_axis_tdata = byte_idx[7:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_traffic_gen.sv
// Self-checking bench for eth_traffic_gen: expected payload beats are queued
// when a run is launched and popped as the DUT hands beats over.
module tb_eth_traffic_gen;

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_00;
  localparam logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [15:0] ETH_TYPE  = 16'h88B5;
  localparam int          MIN_LEN   = 46;
  localparam int          MAX_LEN   = 1500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_len = 16'd0;
  logic [31:0] cfg_count = 32'd0;
  logic [15:0] cfg_gap = 16'd0;
  logic        hdr_valid;
  logic        hdr_ready = 1'b1;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic        tuser;
  logic        busy;
  logic [31:0] frames_sent;

  eth_traffic_gen dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .start                     (start),
    .stop                      (stop),
    .cfg_mode                  (cfg_mode),
    .cfg_len                   (cfg_len),
    .cfg_count                 (cfg_count),
    .cfg_gap                   (cfg_gap),
    .m_eth_hdr_valid           (hdr_valid),
    .m_eth_hdr_ready           (hdr_ready),
    .m_eth_dest_mac            (dest_mac),
    .m_eth_src_mac             (src_mac),
    .m_eth_type                (eth_type),
    .m_eth_payload_axis_tdata  (tdata),
    .m_eth_payload_axis_tvalid (tvalid),
    .m_eth_payload_axis_tready (tready),
    .m_eth_payload_axis_tlast  (tlast),
    .m_eth_payload_axis_tuser  (tuser),
    .busy                      (busy),
    .frames_sent               (frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  logic  rand_ready = 1'b0;
  int    exp_gap = 0;
  logic  gap_armed = 1'b0;
  int    gap_seen = 0;
  logic  stall_pending = 1'b0;
  logic [7:0] stall_data;
  logic  stall_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // PRBS-31 reference: a[k] = a[k-31] ^ a[k-28], first 31 bits all ones.
  function automatic logic [7:0] prbs_ref(input int j);
    bit a[0:511];
    logic [7:0] b;
    for (int k = 0; k < 512; k++) begin
      if (k < 31) a[k] = 1'b1;
      else        a[k] = a[k-31] ^ a[k-28];
    end
    for (int n = 0; n < 8; n++) b[7-n] = a[(j-4)*8 + n];
    return b;
  endfunction

  function automatic int clamp_len(input int len);
    if (len < MIN_LEN) return MIN_LEN;
    if (len > MAX_LEN) return MAX_LEN;
    return len;
  endfunction

  task automatic push_frame(input logic [31:0] seq, input logic [1:0] mode, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      case (j)
        0: b.data = seq[31:24];
        1: b.data = seq[23:16];
        2: b.data = seq[15:8];
        3: b.data = seq[7:0];
        default: begin
          if (mode == 2'd2) b.data = 8'hA5;
`ifdef TRAFFIC_GEN_PRBS_EN
          else if (mode == 2'd1) b.data = prbs_ref(j);
`endif
          else b.data = 8'(j);
        end
      endcase
      b.last = (j == len - 1);
      exp_q.push_back(b);
    end
  endtask

  // Random back-pressure on both handshakes when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) begin
      tready    = 1'($urandom_range(0, 1));
      hdr_ready = 1'($urandom_range(0, 1));
    end else begin
      tready    = 1'b1;
      hdr_ready = 1'b1;
    end
  end

  // Monitor: samples on the falling edge, halfway between active edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy) gap_armed = 1'b0;
      if (gap_armed) begin
        if (hdr_valid) begin
          check("gap_cycles", 64'(gap_seen), 64'(exp_gap));
          gap_armed = 1'b0;
        end else if (!tvalid) begin
          gap_seen++;
        end
      end
      if (hdr_valid && hdr_ready) begin
        check("hdr_dest", dest_mac, DST_MAC);
        check("hdr_src", src_mac, LOCAL_MAC);
        check("hdr_type", eth_type, ETH_TYPE);
      end
      if (tvalid) begin
        if (stall_pending) begin
          check("stall_data", tdata, stall_data);
          check("stall_last", tlast, stall_last);
        end
        if (tready) begin
          stall_pending = 1'b0;
          check("tuser", tuser, 1'b0);
          if (exp_q.size() == 0) begin
            check("extra_beat", 1'b1, 1'b0);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("tdata", tdata, e.data);
            check("tlast", tlast, e.last);
          end
          if (tlast) begin
            gap_armed = 1'b1;
            gap_seen  = 0;
          end
        end else begin
          stall_pending = 1'b1;
          stall_data    = tdata;
          stall_last    = tlast;
        end
      end
    end
  end

  // Launch a run; the expected frames are queued before the start pulse.
  task automatic start_run(input logic [1:0] mode, input logic [15:0] len,
                           input logic [31:0] count, input logic [15:0] gap,
                           input int nframes, input logic with_stop);
    exp_gap = int'(gap);
    for (int f = 0; f < nframes; f++) push_frame(32'(f), mode, clamp_len(int'(len)));
    @(posedge clk);
    #1;
    cfg_mode  = mode;
    cfg_len   = len;
    cfg_count = count;
    cfg_gap   = gap;
    start     = 1'b1;
    stop      = with_stop;
    @(posedge clk);
    #1;
    start     = 1'b0;
    stop      = 1'b0;
    // Scramble the config inputs; the run must use the latched copy.
    cfg_mode  = ~mode;
    cfg_len   = 16'd7;
    cfg_count = 32'd99;
    cfg_gap   = 16'd3;
    @(negedge clk);
    check("hdr_first_cycle", hdr_valid, 1'b1);
    check("busy_on_start", busy, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hdr_valid"}, hdr_valid, 1'b0);
    check({tag, "_tvalid"}, tvalid, 1'b0);
    check({tag, "_tlast"}, tlast, 1'b0);
    check({tag, "_tdata"}, tdata, 8'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_frames"}, frames_sent, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two short incrementing frames, stop coinciding with start is ignored
    start_run(2'd0, 16'd10, 32'd2, 16'd0, 2, 1'b1);
    wait_idle(500);
    check("run1_frames", frames_sent, 32'd2);
    check("run1_drained", 64'(exp_q.size()), 64'd0);

    // Short length clamps to MIN_LEN, constant pattern; start mid-run ignored
    start_run(2'd2, 16'd3, 32'd1, 16'd0, 1, 1'b0);
    repeat (5) @(negedge clk);
    cfg_len = 16'd10;
    cfg_mode = 2'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(500);
    check("run2_frames", frames_sent, 32'd1);
    check("run2_drained", 64'(exp_q.size()), 64'd0);

    // Random back-pressure, 64-byte frame
    rand_ready = 1'b1;
    start_run(2'd0, 16'd64, 32'd1, 16'd0, 1, 1'b0);
    wait_idle(2000);
    rand_ready = 1'b0;
    check("run3_frames", frames_sent, 32'd1);
    check("run3_drained", 64'(exp_q.size()), 64'd0);

    // Continuous run with gap, stop during the third frame's payload
    start_run(2'd0, 16'd0, 32'd0, 16'd5, 3, 1'b0);
    begin
      int n;
      n = 0;
      while (!(frames_sent == 32'd2 && tvalid) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (!(frames_sent == 32'd2 && tvalid)) check("frame3_timeout", 1'b1, 1'b0);
    end
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    wait_idle(2000);
    repeat (3) @(negedge clk);
    check("run4_frames", frames_sent, 32'd3);
    check("run4_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-payload, then a fresh run restarts at sequence 0
    start_run(2'd0, 16'd64, 32'd0, 16'd0, 1, 1'b0);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    stall_pending = 1'b0;
    gap_armed = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(2'd0, 16'd10, 32'd1, 16'd0, 1, 1'b0);
    wait_idle(500);
    check("run5_frames", frames_sent, 32'd1);
    check("run5_drained", 64'(exp_q.size()), 64'd0);

    // PRBS mode (incrementing pattern when the feature is compiled out)
    start_run(2'd1, 16'd8, 32'd1, 16'd0, 1, 1'b0);
    wait_idle(500);
    check("run6_frames", frames_sent, 32'd1);
    check("run6_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
